move_buffer: RTL

- Ring-buffer FIFO of coordinated-move records between the SPI command decoder (write side) and the DDA step executor (read side).
- Decouples SPI message arrival from move execution.
- Provides valid/ready handshakes on both sides, an occupancy count, host flow control (buffer_dtr) and sticky error flags.
- Single clock domain; records are stored, never modified.

---
 rtl/move_buffer.sv | 119 +++++++++++
 1 files changed

// File: rtl/move_buffer.sv
// Ring-buffer FIFO of coordinated-move records between the SPI command decoder and the DDA executor.
// Optional sticky starvation flag `underrun` is built when MOVE_BUFFER_UNDERRUN_EN is defined.
module move_buffer #(
    parameter int DEPTH_BITS = 2,
    parameter int DUR_W      = 32,
    parameter int INC_W      = 64
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  flush,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic                  wr_dir,
    input  logic [DUR_W-1:0]      wr_duration,
    input  logic [INC_W-1:0]      wr_increment,
    input  logic [INC_W-1:0]      wr_incrementincrement,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  rd_dir,
    output logic [DUR_W-1:0]      rd_duration,
    output logic [INC_W-1:0]      rd_increment,
    output logic [INC_W-1:0]      rd_incrementincrement,
    output logic [DEPTH_BITS:0]   count,
    output logic                  buffer_dtr,
    output logic                  overflow
`ifdef MOVE_BUFFER_UNDERRUN_EN
    ,
    output logic                  underrun
`endif
);

    localparam int DEPTH = 2 ** DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] FULL_COUNT = (DEPTH_BITS + 1)'(DEPTH);
    localparam logic [DEPTH_BITS:0] DTR_LIMIT  = (DEPTH_BITS + 1)'(DEPTH - 1);

    typedef struct packed {
        logic             dir;
        logic [DUR_W-1:0] duration;
        logic [INC_W-1:0] increment;
        logic [INC_W-1:0] incrementincrement;
    } move_t;

    move_t                 mem [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr;
    logic [DEPTH_BITS-1:0] rd_ptr;
    logic                  full;
    logic                  empty;
    logic                  wr_fire;
    logic                  rd_fire;
    move_t                 head;

    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    // Ready is derived from registered occupancy only, so rd_ready never reaches wr_ready.
    assign wr_ready = !full;
    assign rd_valid = !empty;
    assign wr_fire  = wr_valid && wr_ready && !flush;
    assign rd_fire  = rd_valid && rd_ready && !flush;
    assign buffer_dtr = (count < DTR_LIMIT);

    assign head                  = mem[rd_ptr];
    assign rd_dir                = head.dir;
    assign rd_duration           = head.duration;
    assign rd_increment          = head.increment;
    assign rd_incrementincrement = head.incrementincrement;

    // NOTE: the storage array has no reset; occupancy alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr] <= '{dir:                wr_dir,
                             duration:           wr_duration,
                             increment:          wr_increment,
                             incrementincrement: wr_incrementincrement};
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
            if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_fire, rd_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wr_valid && !wr_ready) overflow <= 1'b1;
        end
    end

`ifdef MOVE_BUFFER_UNDERRUN_EN
    logic primed;

    // Starvation only counts once the executor has consumed at least one move.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            primed   <= 1'b0;
            underrun <= 1'b0;
        end else if (flush) begin
            primed   <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (rd_fire) primed <= 1'b1;
            if (primed && empty && rd_ready) underrun <= 1'b1;
        end
    end
`endif

endmodule
